// File: rtl/accumulator_reg_pkg.sv
// Shared definitions for the accumulator register: operation codes and their width.
package acc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_ROL  = 3'd7
  } op_e;

endpackage

// File: rtl/accumulator_reg_if.sv
// Bus between the control unit / keyboard / ALU and the accumulator register.
// Handshake: there is no back-pressure. KbdStrobe is a one-cycle pulse and En
// qualifies Op; both are sampled on the rising edge they are high for, and the
// resulting update is visible on AccOut/Carry/Full/Overrun one edge later.
interface accumulator_reg_if #(
  parameter int WIDTH = 8,
  parameter int KBD_W = 4
);
  import acc_pkg::*;

  logic [KBD_W-1:0] Kbd;
  logic             KbdStrobe;
  logic             En;
  op_e              Op;
  logic [WIDTH-1:0] AluIn;
  logic             AluCarry;
  logic [WIDTH-1:0] AccOut;
  logic             Zero;
  logic             Carry;
  logic             Full;
  logic             Overrun;

  modport master (
    output Kbd, KbdStrobe, En, Op, AluIn, AluCarry,
    input  AccOut, Zero, Carry, Full, Overrun
  );

  modport slave (
    input  Kbd, KbdStrobe, En, Op, AluIn, AluCarry,
    output AccOut, Zero, Carry, Full, Overrun
  );

endinterface

// File: rtl/accumulator_reg_digit_ctr.sv
// Counts keyboard digits entered into the current operand, 0..NIB.
// clr (an executed op) beats restart (first digit of a new entry) beats inc.
module acc_digit_ctr #(
  parameter int NIB = 2,
  localparam int CW = $clog2(NIB + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          restart,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          full
);

  // Digit count and registered Full flag.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      full  <= 1'b0;
    end else if (restart) begin
      count <= CW'(1);
      full  <= (NIB == 1);
    end else if (inc) begin
      count <= count + CW'(1);
      full  <= (count == CW'(NIB - 1));
    end
  end

endmodule

// File: rtl/accumulator_reg.sv
// Parametrised accumulator register: ALU operand holder, keyboard digit
// assembler and in-place op engine with Zero/Carry/Full/Overrun status.
module accumulator_reg
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KBD_W = 4
) (
  input  logic         MainClock,
  input  logic         Clear,
  accumulator_reg_if.slave bus
);

  localparam int NIB = WIDTH / KBD_W;
  localparam int CW  = $clog2(NIB + 1);

  logic [WIDTH-1:0] acc, acc_nxt;
  logic             carry, carry_nxt;
  logic             overrun;
  logic [WIDTH:0]   inc_sum, dec_sum;
  logic             op_exec, strobe_ok, full;
  logic [CW-1:0]    digit_count;

  // An op executes only when En is high with a non-HOLD code; strobes lose to it.
  assign op_exec   = bus.En && (bus.Op != OP_HOLD);
  assign strobe_ok = bus.KbdStrobe && !op_exec;
  assign inc_sum   = {1'b0, acc} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_sum   = {1'b0, acc} - {{WIDTH{1'b0}}, 1'b1};

  acc_digit_ctr #(.NIB(NIB)) u_digit_ctr (
    .clk     (MainClock),
    .rst     (Clear),
    .clr     (op_exec),
    .restart (strobe_ok && full),
    .inc     (strobe_ok && !full),
    .count   (digit_count),
    .full    (full)
  );

  // Next accumulator/carry: executed op first, then an accepted keyboard digit.
  always_comb begin
    acc_nxt   = acc;
    carry_nxt = carry;
    if (op_exec) begin
      case (bus.Op)
        OP_LOAD: begin acc_nxt = bus.AluIn; carry_nxt = bus.AluCarry; end
        OP_CLR:  begin acc_nxt = '0; carry_nxt = 1'b0; end
        OP_INC:  {carry_nxt, acc_nxt} = inc_sum;
        OP_DEC:  {carry_nxt, acc_nxt} = dec_sum;
        OP_SHL:  begin carry_nxt = acc[WIDTH-1]; acc_nxt = {acc[WIDTH-2:0], 1'b0}; end
        OP_SHR:  begin carry_nxt = acc[0]; acc_nxt = {1'b0, acc[WIDTH-1:1]}; end
        OP_ROL:  begin carry_nxt = acc[WIDTH-1]; acc_nxt = {acc[WIDTH-2:0], acc[WIDTH-1]}; end
        default: begin acc_nxt = acc; carry_nxt = carry; end
      endcase
    end else if (strobe_ok) begin
      // A full operand means this digit starts a fresh entry.
      if (full) acc_nxt = WIDTH'(bus.Kbd);
      else      acc_nxt = (acc << KBD_W) | WIDTH'(bus.Kbd);
    end
  end

  // State registers; Clear wins over everything.
  always_ff @(posedge MainClock) begin
    if (Clear) begin
      acc     <= '0;
      carry   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      carry   <= carry_nxt;
      overrun <= bus.KbdStrobe && op_exec;
    end
  end

  assign bus.AccOut  = acc;
  assign bus.Zero    = (acc == '0);
  assign bus.Carry   = carry;
  assign bus.Full    = full;
  assign bus.Overrun = overrun;

endmodule

// File: tb/tb_accumulator_reg.sv
// Directed bench for accumulator_reg (WIDTH=8, KBD_W=4) with a queue scoreboard.
module tb_accumulator_reg;
  import acc_pkg::*;

  localparam int EW = 12; // {acc[7:0], carry, full, overrun, zero}

  logic clk;
  logic clear;

  accumulator_reg_if #(.WIDTH(8), .KBD_W(4)) bus_if ();

  accumulator_reg #(.WIDTH(8), .KBD_W(4)) dut (
    .MainClock (clk),
    .Clear     (clear),
    .bus       (bus_if)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;

  // Monitor: outputs are stable at the falling edge; one expectation per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus_if.AccOut, bus_if.Carry, bus_if.Full, bus_if.Overrun, bus_if.Zero};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got acc=%h c=%b full=%b ovr=%b zero=%b, want acc=%h c=%b full=%b ovr=%b zero=%b",
                 nm, a[11:4], a[3], a[2], a[1], a[0], e[11:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // Driver: apply one cycle of inputs and queue the expected post-edge state.
  task automatic step(input string nm, input logic clr, input logic en, input op_e op,
                      input logic strb, input logic [3:0] kbd, input logic [7:0] alu,
                      input logic aluc, input logic [7:0] e_acc, input logic e_c,
                      input logic e_full, input logic e_ovr);
    @(negedge clk);
    #1;
    clear            = clr;
    bus_if.En        = en;
    bus_if.Op        = op;
    bus_if.KbdStrobe = strb;
    bus_if.Kbd       = kbd;
    bus_if.AluIn     = alu;
    bus_if.AluCarry  = aluc;
    exp_q.push_back({e_acc, e_c, e_full, e_ovr, (e_acc == 8'h00)});
    name_q.push_back(nm);
  endtask

  task automatic strobe(input string nm, input logic [3:0] kbd,
                        input logic [7:0] e_acc, input logic e_c, input logic e_full);
    step(nm, 0, 0, OP_HOLD, 1, kbd, 8'h00, 0, e_acc, e_c, e_full, 0);
  endtask

  task automatic op(input string nm, input op_e o, input logic [7:0] alu, input logic aluc,
                    input logic [7:0] e_acc, input logic e_c);
    step(nm, 0, 1, o, 0, 4'h0, alu, aluc, e_acc, e_c, 0, 0);
  endtask

  initial begin
    clear            = 1'b1;
    bus_if.En        = 1'b0;
    bus_if.Op        = OP_HOLD;
    bus_if.KbdStrobe = 1'b0;
    bus_if.Kbd       = '0;
    bus_if.AluIn     = '0;
    bus_if.AluCarry  = 1'b0;

    step("reset", 1, 0, OP_HOLD, 0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0);

    // 1. Reset mid-entry
    strobe("t1_strobe3", 4'h3, 8'h03, 0, 0);
    step("t1_clear_over_strobe", 1, 0, OP_HOLD, 1, 4'h5, 8'h00, 0, 8'h00, 0, 0, 0);

    // 2. Digit entry and new-entry restart
    strobe("t2_digitA", 4'hA, 8'h0A, 0, 0);
    strobe("t2_digit5", 4'h5, 8'hA5, 0, 1);
    strobe("t2_restart7", 4'h7, 8'h07, 0, 0);

    // 3. Arithmetic wrap
    op("t3_load_ff", OP_LOAD, 8'hFF, 0, 8'hFF, 0);
    op("t3_inc_wrap", OP_INC, 8'h00, 0, 8'h00, 1);
    op("t3_dec_borrow", OP_DEC, 8'h00, 0, 8'hFF, 1);
    op("t3_dec_plain", OP_DEC, 8'h00, 0, 8'hFE, 0);

    // 4. Shifts and rotate
    op("t4_load_81", OP_LOAD, 8'h81, 0, 8'h81, 0);
    op("t4_shl", OP_SHL, 8'h00, 0, 8'h02, 1);
    op("t4_shr", OP_SHR, 8'h00, 0, 8'h01, 0);
    op("t4_shr_out", OP_SHR, 8'h00, 0, 8'h00, 1);
    op("t4_reload_81", OP_LOAD, 8'h81, 0, 8'h81, 0);
    op("t4_rol", OP_ROL, 8'h00, 0, 8'h03, 1);

    // 5. Strobe colliding with an op, then with HOLD
    op("t5_load_10", OP_LOAD, 8'h10, 0, 8'h10, 0);
    step("t5_inc_overrun", 0, 1, OP_INC, 1, 4'h9, 8'h00, 0, 8'h11, 0, 0, 1);
    step("t5_hold_strobe", 0, 1, OP_HOLD, 1, 4'h9, 8'h00, 0, 8'h19, 0, 0, 0);
    step("t5_idle", 0, 0, OP_HOLD, 0, 4'h0, 8'h00, 0, 8'h19, 0, 0, 0);

    // 6. Executed op clears the entry in progress
    op("t6_clr", OP_CLR, 8'h00, 0, 8'h00, 0);
    strobe("t6_digit1", 4'h1, 8'h01, 0, 0);
    strobe("t6_digit2", 4'h2, 8'h12, 0, 1);
    op("t6_clr_full", OP_CLR, 8'h00, 0, 8'h00, 0);
    strobe("t6_digit4", 4'h4, 8'h04, 0, 0);

    // Carry survives strobes; LOAD takes AluCarry
    op("x_load_carry", OP_LOAD, 8'h3C, 1, 8'h3C, 1);
    strobe("x_strobe_keeps_carry", 4'hB, 8'hCB, 1, 0);
    op("x_rol_c0", OP_ROL, 8'h00, 0, 8'h97, 1);

    step("drain", 0, 0, OP_HOLD, 0, 4'h0, 8'h00, 0, 8'h97, 1, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
